// File: rtl/inst_queue_pkg.sv
// Shared sizing constants and helpers for the instruction queue between fetch and decode.
package inst_queue_pkg;

  localparam int IQ_SIZE  = 16;
  localparam int IQ_PTR_W = 4;
  localparam int DATA_W   = 32;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  // Any downstream structure that cannot take a new instruction blocks issue.
  function automatic logic any_downstream_full(input logic rs_full,
                                               input logic lsb_full,
                                               input logic rob_full);
    return rs_full | lsb_full | rob_full;
  endfunction

endpackage

// File: rtl/inst_queue.sv
// Circular FIFO of fetched instructions and their PCs; issues one entry per cycle to the
// decoder when RS, LSB and ROB can all accept, and empties completely on ROB roll-back.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int IQ_DEPTH   = IQ_SIZE,
  parameter int DATA_WIDTH = DATA_W,
  parameter int PTR_WIDTH  = IQ_PTR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  IF_input_valid,
  input  logic [DATA_WIDTH-1:0] IF_inst,
  input  logic [DATA_WIDTH-1:0] IF_inst_pc,
  output logic                  IF_IQ_is_full,
  input  logic                  RS_is_full,
  input  logic                  LSB_is_full,
  input  logic                  ROB_is_full,
  output logic                  ID_output_valid,
  output logic [DATA_WIDTH-1:0] ID_inst,
  output logic [DATA_WIDTH-1:0] ID_inst_pc,
  input  logic                  ROB_roll_back_flag
);

  localparam logic [PTR_WIDTH:0]   FULL_COUNT = (PTR_WIDTH+1)'(IQ_DEPTH);
  localparam logic [PTR_WIDTH:0]   CNT_ONE    = (PTR_WIDTH+1)'(1);
  localparam logic [PTR_WIDTH-1:0] PTR_ONE    = PTR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] inst_mem [IQ_DEPTH];
  logic [DATA_WIDTH-1:0] pc_mem   [IQ_DEPTH];
  logic [PTR_WIDTH-1:0]  head;
  logic [PTR_WIDTH-1:0]  tail;
  logic [PTR_WIDTH:0]    count;

  logic stall;
  logic pop;
  logic push;

  // A pop in the same cycle frees a slot, so a full queue still accepts a push then.
  assign stall         = any_downstream_full(RS_is_full, LSB_is_full, ROB_is_full);
  assign pop           = (count != '0) & ~stall;
  assign push          = IF_input_valid & ((count != FULL_COUNT) | pop);
  assign IF_IQ_is_full = (count == FULL_COUNT);

  always_ff @(posedge clk) begin
    if (rst | ROB_roll_back_flag) begin
      head            <= '0;
      tail            <= '0;
      count           <= '0;
      ID_output_valid <= FALSE;
      ID_inst         <= '0;
      ID_inst_pc      <= '0;
    end else if (!rdy) begin
      ID_output_valid <= FALSE;
    end else begin
      ID_output_valid <= pop;
      // When full, head == tail: the read below sees the old entry before the write lands.
      if (pop) begin
        ID_inst    <= inst_mem[head];
        ID_inst_pc <= pc_mem[head];
        head       <= head + PTR_ONE;
      end
      if (push) begin
        inst_mem[tail] <= IF_inst;
        pc_mem[tail]   <= IF_inst_pc;
        tail           <= tail + PTR_ONE;
      end
      if (push & ~pop) begin
        count <= count + CNT_ONE;
      end else if (pop & ~push) begin
        count <= count - CNT_ONE;
      end
    end
  end

endmodule
